// File: rtl/tcam_pipe_pkg.sv
// tcam_pkg: request opcodes shared by the TCAM, its request front end and the bench.
package tcam_pkg;
    localparam int TCAM_OP_WIDTH = 2;
    typedef enum logic [TCAM_OP_WIDTH-1:0] {
        OP_SEARCH = 2'd0,
        OP_WRITE  = 2'd1,
        OP_INVAL  = 2'd2
    } tcam_op_t;
endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: combinational lowest-index priority encoder over a match vector.
module tcam_prio_enc #(
    parameter  int TCAM_DEPTH = 16,
    localparam int IW         = $clog2(TCAM_DEPTH)
) (
    input  logic [TCAM_DEPTH-1:0] vec,
    output logic                  hit,
    output logic [IW-1:0]         idx
);
    always_comb begin
        idx = '0;
        for (int i = TCAM_DEPTH - 1; i >= 0; i--)
            if (vec[i]) idx = IW'(i);
    end
    assign hit = |vec;
endmodule

// File: rtl/tcam_pipe.sv
// tcam_pipe: two-stage ternary CAM with valid/ready request and response channels.
// S1 latches the match vector, S2 priority-encodes it and reads the winning entry.
module tcam_pipe
    import tcam_pkg::*;
#(
    parameter  int TCAM_WIDTH       = 32,
    parameter  int TCAM_DEPTH       = 16,
    localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [TCAM_OP_WIDTH-1:0]    req_op,
    input  logic [TCAM_INDEX_WIDTH-1:0] req_idx,
    input  logic [TCAM_WIDTH-1:0]       req_data,
    input  logic [TCAM_WIDTH-1:0]       req_mask,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_hit,
    output logic [TCAM_INDEX_WIDTH-1:0] resp_idx,
    output logic [TCAM_WIDTH-1:0]       resp_data
);
    logic [TCAM_WIDTH-1:0]       data_q [TCAM_DEPTH];
    logic [TCAM_WIDTH-1:0]       mask_q [TCAM_DEPTH];
    logic [TCAM_DEPTH-1:0]       vld_q, m1_q, match;
    logic                        v1_q, adv, acc, enc_hit;
    logic [TCAM_INDEX_WIDTH-1:0] enc_idx;

    assign adv       = !resp_valid || resp_ready;
    assign req_ready = adv;
    assign acc       = req_valid && adv;

    // Key bits are never masked; only the stored mask marks don't-care positions.
    always_comb begin
        match = '0;
        for (int i = 0; i < TCAM_DEPTH; i++)
            match[i] = vld_q[i] && (((data_q[i] ^ req_data) & ~mask_q[i]) == '0);
    end

    tcam_prio_enc #(.TCAM_DEPTH(TCAM_DEPTH)) u_enc (
        .vec(m1_q),
        .hit(enc_hit),
        .idx(enc_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TCAM_DEPTH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (acc && req_op == OP_WRITE) begin
            data_q[req_idx] <= req_data;
            mask_q[req_idx] <= req_mask;
            vld_q[req_idx]  <= 1'b1;
        end else if (acc && req_op == OP_INVAL) begin
            vld_q[req_idx]  <= 1'b0;
        end
    end

    // Both stages advance together; a stalled response freezes the whole pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q       <= 1'b0;
            m1_q       <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
            resp_data  <= '0;
        end else if (adv) begin
            v1_q       <= acc && req_op == OP_SEARCH;
            m1_q       <= match;
            resp_valid <= v1_q;
            resp_hit   <= enc_hit;
            resp_idx   <= enc_idx;
            resp_data  <= enc_hit ? data_q[enc_idx] : '0;
        end
    end
endmodule

// File: tb/tb_tcam_pipe.sv
// tb_tcam_pipe: scoreboard bench for tcam_pipe; a behavioural TCAM model predicts
// each search result at acceptance and a monitor checks responses in order.
module tb_tcam_pipe;
    import tcam_pkg::*;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int IW = 4;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b0;
    logic          req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1, resp_hit;
    logic [1:0]    req_op = 2'd0;
    logic [IW-1:0] req_idx = '0, resp_idx;
    logic [W-1:0]  req_data = '0, req_mask = '0, resp_data;

    exp_t          sbq[$];
    exp_t          e;
    logic [W-1:0]  md[D], mm[D];
    logic          mv[D];
    int            n_pass = 0, n_tot = 0;
    logic          hold = 1'b0, h_hit;
    logic [IW-1:0] h_idx;
    logic [W-1:0]  h_data;

    tcam_pipe #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_data(req_data), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_idx(resp_idx), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    // Reference: first valid entry (ascending) whose unmasked bits equal the key.
    function automatic exp_t model_search(logic [W-1:0] k);
        exp_t r = '{1'b0, '0, '0};
        for (int i = 0; i < D; i++)
            if (mv[i] && ((md[i] ^ k) & ~mm[i]) == '0) begin
                r = '{1'b1, IW'(i), md[i]};
                break;
            end
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < D; i++) begin
            md[i] = '0; mm[i] = '0; mv[i] = 1'b0;
        end
    endfunction

    // One clock of stimulus; acc reports whether the request is taken at the next edge.
    task automatic cycle(input logic v, input logic [1:0] op, input int idx,
                         input logic [W-1:0] d, input logic [W-1:0] m,
                         input logic rr, output logic acc);
        @(posedge clk); #1;
        req_valid = v; req_op = op; req_idx = IW'(idx);
        req_data = d; req_mask = m; resp_ready = rr;
        @(negedge clk);
        acc = v && req_ready;
        if (acc)
            case (op)
                2'd0: sbq.push_back(model_search(d));
                2'd1: begin md[idx] = d; mm[idx] = m; mv[idx] = 1'b1; end
                2'd2: mv[idx] = 1'b0;
                default: ;
            endcase
    endtask

    task automatic send(input logic [1:0] op, input int idx, input logic [W-1:0] d,
                        input logic [W-1:0] m);
        logic acc;
        int n = 0;
        do begin
            cycle(1'b1, op, idx, d, m, 1'b1, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 2'd0, 0, '0, '0, 1'b1, acc);
    endtask

    always @(negedge clk) begin
        if (!rst) hold <= 1'b0;
        else begin
            chk("req_ready", 64'(req_ready), 64'(!resp_valid || resp_ready));
            if (hold) begin
                chk("stall_valid", 64'(resp_valid), 64'd1);
                chk("stall_hold", {31'd0, h_hit, 28'd0, h_idx}, {31'd0, resp_hit, 28'd0, resp_idx});
                chk("stall_data", 64'(resp_data), 64'(h_data));
            end
            if (resp_valid && resp_ready) begin
                if (sbq.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("resp_hit", 64'(resp_hit), 64'(e.hit));
                    chk("resp_idx", 64'(resp_idx), 64'(e.idx));
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                end
            end
            hold <= resp_valid && !resp_ready;
            h_hit <= resp_hit; h_idx <= resp_idx; h_data <= resp_data;
        end
    end

    initial begin
        logic acc;
        int j;
        logic rrp[12];
        logic [W-1:0] ks[5];
        logic [W-1:0] kp[4];
        logic [W-1:0] mp[4];
        logic [W-1:0] d;
        int r;
        model_clear();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_idx", 64'(resp_idx), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        #11 rst = 1'b1;

        send(OP_SEARCH, 0, 32'h1234_5678, '0);
        idle(1);
        chk("lat_edge1", 64'(resp_valid), 64'd0);
        idle(1);
        chk("lat_edge2", 64'(resp_valid), 64'd1);
        idle(2);

        send(OP_WRITE, 3, 32'hDEAD_BEEF, '0);
        send(OP_SEARCH, 0, 32'hDEAD_BEEF, '0);
        send(OP_SEARCH, 0, 32'hDEAD_BEEE, '0);
        send(OP_WRITE, 5, 32'hAB00_0000, 32'h00FF_FFFF);
        send(OP_WRITE, 9, 32'hAB12_3456, '0);
        send(OP_SEARCH, 0, 32'hAB12_3456, '0);
        send(OP_INVAL, 5, '0, '0);
        send(OP_SEARCH, 0, 32'hAB12_3456, '0);
        send(2'd3, 9, '0, '0);
        send(OP_SEARCH, 0, 32'hAB12_3456, '0);
        idle(3);

        rrp = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        ks  = '{32'hDEAD_BEEF, 32'hAB12_3456, 32'h0, 32'hAB77_0001, 32'hDEAD_BEEF};
        j = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(j < 5, OP_SEARCH, 0, ks[j < 5 ? j : 0], '0, rrp[c], acc);
            if (acc) j++;
        end
        chk("pattern_issued", 64'(j), 64'd5);
        idle(3);

        send(OP_WRITE, 7, 32'h7777_0000, '0);
        send(OP_SEARCH, 0, 32'h7777_0000, '0);
        send(OP_WRITE, 7, 32'h1111_1111, '0);
        send(OP_SEARCH, 0, 32'h7777_0000, '0);
        idle(3);

        send(OP_SEARCH, 0, 32'hDEAD_BEEF, '0);
        send(OP_SEARCH, 0, 32'hAB12_3456, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd1);
        chk("async_rst_hit", 64'(resp_hit), 64'd0);
        sbq.delete();
        model_clear();
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        send(OP_SEARCH, 0, 32'hDEAD_BEEF, '0);
        idle(3);

        kp = '{32'hA5A5_0000, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
        mp = '{32'h0, 32'h0000_00FF, 32'hFFFF_0000, 32'hFFFF_FFFF};
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            d = kp[$urandom_range(0, 3)] ^ ($urandom_range(0, 3) == 0 ? W'($urandom_range(0, 255)) : '0);
            cycle($urandom_range(0, 4) != 0, r < 5 ? 2'd0 : r < 8 ? 2'd1 : r < 9 ? 2'd2 : 2'd3,
                  $urandom_range(0, D - 1), d, mp[$urandom_range(0, 3)],
                  $urandom_range(0, 9) < 7, acc);
        end
        idle(6);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
